conv1d_feeder: RTL

CONV1D_FEEDER -- requirements
Module: conv1d_feeder

---
 rtl/conv1d_feeder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/conv1d_feeder.sv
// conv1d_feeder: sequences a 3-tap 1-D convolution over a fixed memory map.
// Weights W0..W2 sit at addresses 0..2, feature x[n] at address 3+n.
// The block loads the three weights into an external MAC, then slides the
// feature window one sample at a time, emitting one result per window.
// Optional feature: define CONV1D_RELU_EN to clamp negative results to 0.
// dbg_state exposes the FSM state encoding for observation.
//
// Result handshake (valid/ready): res_valid rises on the first EMIT cycle
// and stays high, with res_data held stable, until a cycle in which
// res_valid & res_ready are both 1; that cycle is the transfer, and
// res_valid is low on the next cycle. res_ready is ignored while
// res_valid is low.
module conv1d_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  len,
   output logic        mem_rd,
   output logic [8:0]  mem_addr,
   input  logic [15:0] mem_rdata,
   output logic        mac_clear,
   output logic        mac_w_w,
   output logic [15:0] mac_w_in,
   output logic        mac_if_w,
   output logic [15:0] mac_if_in,
   input  logic [33:0] mac_out,
   output logic        res_valid,
   output logic [33:0] res_data,
   input  logic        res_ready,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_LDW  = 3'd2,
      S_FRD  = 3'd3,
      S_FSH  = 3'd4,
      S_EMIT = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  fed_q, fed_d;     // features shifted into the MAC so far
   logic [7:0]  len_q, len_d;     // job length latched on accepted start
   logic [1:0]  ldw_q, ldw_d;     // weight-load cycle index, 0..3
   logic        first_q, first_d; // high during the first EMIT cycle only
   logic [33:0] res_q, res_d;     // result captured at the end of the first EMIT cycle
   logic [33:0] res_cap;          // value to be reported for the current window

   // Result shaping: optional clamp of negative sums to zero.
`ifdef CONV1D_RELU_EN
   assign res_cap = mac_out[33] ? 34'd0 : mac_out;
`else
   assign res_cap = mac_out;
`endif

   assign dbg_state = state_q;

   // State and datapath registers; reset abandons any job in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         fed_q   <= 8'd0;
         len_q   <= 8'd0;
         ldw_q   <= 2'd0;
         first_q <= 1'b0;
         res_q   <= 34'd0;
      end else begin
         state_q <= state_d;
         fed_q   <= fed_d;
         len_q   <= len_d;
         ldw_q   <= ldw_d;
         first_q <= first_d;
         res_q   <= res_d;
      end
   end

   // Next-state and output decode; every output defaults to its idle value.
   always_comb begin
      state_d   = state_q;
      fed_d     = fed_q;
      len_d     = len_q;
      ldw_d     = ldw_q;
      first_d   = 1'b0;
      res_d     = res_q;
      mem_rd    = 1'b0;
      mem_addr  = 9'd0;
      mac_clear = 1'b0;
      mac_w_w   = 1'b0;
      mac_w_in  = 16'd0;
      mac_if_w  = 1'b0;
      mac_if_in = 16'd0;
      res_valid = 1'b0;
      res_data  = res_q;
      busy      = 1'b1;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               fed_d = 8'd0;
               if (len >= 8'd3) begin
                  len_d   = len;
                  state_d = S_CLR;
               end else begin
                  // Too short to form a single window: finish without reads.
                  state_d = S_DONE;
               end
            end
         end

         S_CLR: begin
            // Clearing first guarantees nothing stale from an aborted job survives.
            mac_clear = 1'b1;
            ldw_d     = 2'd0;
            state_d   = S_LDW;
         end

         S_LDW: begin
            // Reads go out on cycles 0..2; each word returns and is shifted
            // into the MAC one cycle later (cycles 1..3).
            if (ldw_q != 2'd3) begin
               mem_rd   = 1'b1;
               mem_addr = {7'd0, ldw_q};
            end
            if (ldw_q != 2'd0) begin
               mac_w_w  = 1'b1;
               mac_w_in = mem_rdata;
            end
            if (ldw_q == 2'd3) begin
               state_d = S_FRD;
            end else begin
               ldw_d = ldw_q + 2'd1;
            end
         end

         S_FRD: begin
            // 9-bit address so len=255 reaches 257 without wrapping.
            mem_rd   = 1'b1;
            mem_addr = {1'b0, fed_q} + 9'd3;
            state_d  = S_FSH;
         end

         S_FSH: begin
            mac_if_w  = 1'b1;
            mac_if_in = mem_rdata;
            fed_d     = fed_q + 8'd1;
            if (fed_d >= 8'd3) begin
               first_d = 1'b1;
               state_d = S_EMIT;
            end else begin
               state_d = S_FRD;
            end
         end

         S_EMIT: begin
            // The MAC settled at the edge that ended FSH, so its sum is
            // presented directly on the first cycle and held thereafter.
            res_valid = 1'b1;
            if (first_q) begin
               res_data = res_cap;
               res_d    = res_cap;
            end
            if (res_ready) begin
               state_d = (fed_q == len_q) ? S_DONE : S_FRD;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
